alu_exec: RTL

ALU_EXEC -- requirements
Module: alu_exec

---
 rtl/alu_exec_pkg.sv | 23 ++
 rtl/alu_exec_logic.sv | 26 ++
 rtl/alu_exec.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/alu_exec_pkg.sv
// Shared definitions for the alu_exec block: opcodes, FSM states, default width.
package alu_exec_pkg;

  localparam int unsigned DataWDefault = 8;

  typedef enum logic [2:0] {
    OpFwd = 3'b000,
    OpAdd = 3'b001,
    OpAnd = 3'b010,
    OpOr  = 3'b011,
    OpSub = 3'b100,
    OpSll = 3'b101,
    OpSra = 3'b110,
    OpMul = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StExec = 2'b01,
    StDone = 2'b10
  } state_e;

endpackage

// File: rtl/alu_exec_logic.sv
// Single-cycle ALU operations (FWD/ADD/AND/OR/SUB); multi-cycle opcodes yield zero here.
module alu_exec_logic
  import alu_exec_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault
) (
  input  opcode_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  // Decode the single-cycle operation.
  always_comb begin
    y = '0;
    case (op)
      OpFwd:   y = b;
      OpAdd:   y = a + b;
      OpAnd:   y = a & b;
      OpOr:    y = a | b;
      OpSub:   y = a - b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec.sv
// Multi-cycle ALU execute stage: IDLE -> EXEC -> DONE sequencer, bit-serial shifter and
// optional shift-add multiplier. Define ALU_EXEC_MUL_EN to build the multiplier; without it
// opcode 111 completes after one EXEC cycle with DONE but no write.
// DONE, WRITE_EN, RESULT and ZERO are registered on the edge that leaves the DONE state, so
// the strobe of an op accepted at edge N is visible between edges N+2 and N+3 while the FSM
// is already back in IDLE and able to accept at N+3.
module alu_exec
  import alu_exec_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [2:0]        OPCODE,
  input  logic [DATA_W-1:0] DATA1,
  input  logic [DATA_W-1:0] DATA2,
  output logic [DATA_W-1:0] RESULT,
  output logic              WRITE_EN,
  output logic              BUSY,
  output logic              DONE,
  output logic              ZERO
);

  localparam int unsigned ShiftW = $clog2(DATA_W);
  // One extra bit so the counter can hold DATA_W for the multiplier.
  localparam int unsigned CntW   = ShiftW + 1;

  state_e            state_q, state_d;
  opcode_e           op_q;
  logic [DATA_W-1:0] opa_q, opb_q, acc_q;
  logic [CntW-1:0]   cnt_q;
  logic [DATA_W-1:0] result_q;
  logic              zero_q, done_q, wen_q;
  logic [DATA_W-1:0] logic_y;
  logic              accept, exec_step, commit, busy;
  logic              exec_last, write_ok;

  alu_exec_logic #(
    .DATA_W(DATA_W)
  ) u_logic (
    .op(op_q),
    .a (opa_q),
    .b (opb_q),
    .y (logic_y)
  );

  // A counter of 0 or 1 means the current EXEC cycle is the final one.
  assign exec_last = (cnt_q <= CntW'(1));

`ifdef ALU_EXEC_MUL_EN
  assign write_ok = 1'b1;
`else
  assign write_ok = (op_q != OpMul);
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (START) state_d = StExec;
      StExec:  if (exec_last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM control outputs.
  always_comb begin
    accept    = 1'b0;
    exec_step = 1'b0;
    commit    = 1'b0;
    unique case (state_q)
      StIdle:  accept    = START;
      StExec:  exec_step = 1'b1;
      StDone:  commit    = 1'b1;
      default: ;
    endcase
    busy = (state_q != StIdle) | done_q;
  end

  // Operand latch and iterative datapath (shifter / multiplier / single-cycle capture).
  always_ff @(posedge CLK) begin
    if (RESET) begin
      op_q  <= OpFwd;
      opa_q <= '0;
      opb_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      op_q  <= opcode_e'(OPCODE);
      opa_q <= DATA1;
      opb_q <= DATA2;
      acc_q <= '0;
      cnt_q <= '0;
      case (opcode_e'(OPCODE))
        OpSll, OpSra: begin
          acc_q <= DATA1;
          cnt_q <= {1'b0, DATA2[ShiftW-1:0]};
        end
`ifdef ALU_EXEC_MUL_EN
        OpMul: cnt_q <= CntW'(DATA_W);
`endif
        default: ;
      endcase
    end else if (exec_step) begin
      case (op_q)
        OpSll: begin
          if (cnt_q != '0) begin
            acc_q <= acc_q << 1;
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        OpSra: begin
          if (cnt_q != '0) begin
            acc_q <= {acc_q[DATA_W-1], acc_q[DATA_W-1:1]};
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        OpMul: begin
`ifdef ALU_EXEC_MUL_EN
          // Shift-add: consume one multiplier bit (LSB of opb_q) per cycle.
          acc_q <= acc_q + (opb_q[0] ? opa_q : '0);
          opa_q <= opa_q << 1;
          opb_q <= opb_q >> 1;
          cnt_q <= cnt_q - CntW'(1);
`endif
        end
        default: acc_q <= logic_y;
      endcase
    end
  end

  // Registered architectural outputs; only a committed, writable op touches RESULT/ZERO.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
      wen_q    <= 1'b0;
    end else begin
      done_q <= commit;
      wen_q  <= commit & write_ok;
      if (commit && write_ok) begin
        result_q <= acc_q;
        zero_q   <= (acc_q == '0);
      end
    end
  end

  assign RESULT   = result_q;
  assign ZERO     = zero_q;
  assign DONE     = done_q;
  assign WRITE_EN = wen_q;
  assign BUSY     = busy;

endmodule
